// File: rtl/branch_flag_unit_pkg.sv
// Shared encodings for the branch/flag unit: control opcodes (kept identical to the
// ALU control encoding), CCR bit positions and the sequencer state type.
package branch_flag_unit_pkg;

  localparam logic [4:0] OP_SETC = 5'd1;
  localparam logic [4:0] OP_CLRC = 5'd2;
  localparam logic [4:0] OP_JZ   = 5'd20;
  localparam logic [4:0] OP_JN   = 5'd21;
  localparam logic [4:0] OP_JC   = 5'd22;
  localparam logic [4:0] OP_JMP  = 5'd23;
  localparam logic [4:0] OP_CALL = 5'd24;
  localparam logic [4:0] OP_RET  = 5'd25;
  localparam logic [4:0] OP_RETI = 5'd26;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RET_WAIT  = 2'd1,
    ST_RETI_WAIT = 2'd2
  } state_t;

  // Per-bit merge of ALU flag results into the current CCR.
  function automatic logic [3:0] merge_flags(input logic [3:0] ccr_q,
                                             input logic [3:0] flags,
                                             input logic [3:0] we);
    return (ccr_q & ~we) | (flags & we);
  endfunction

endpackage

// File: rtl/branch_flag_unit_cond_eval.sv
// Combinational branch condition evaluation: decides whether a jump opcode is taken
// against the effective flags and which CCR bit the taken jump consumes.
module branch_cond_eval
  import branch_flag_unit_pkg::*;
(
  input  logic [4:0] i_op,
  input  logic [3:0] i_eff,
  output logic       o_taken,
  output logic [3:0] o_clr_mask
);

  always_comb begin
    o_taken    = 1'b0;
    o_clr_mask = 4'b0000;
    case (i_op)
      OP_JZ: begin
        o_taken            = i_eff[FLAG_Z];
        o_clr_mask[FLAG_Z] = i_eff[FLAG_Z];
      end
      OP_JN: begin
        o_taken            = i_eff[FLAG_N];
        o_clr_mask[FLAG_N] = i_eff[FLAG_N];
      end
      OP_JC: begin
        o_taken            = i_eff[FLAG_C];
        o_clr_mask[FLAG_C] = i_eff[FLAG_C];
      end
      OP_JMP:  o_taken = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_flag_unit.sv
// Branch/flag unit: owns the CCR, resolves control-flow opcodes into fetch redirects,
// sequences stack push/pop for CALL/RET/interrupts and shadows the CCR for one ISR level.
module branch_flag_unit
  import branch_flag_unit_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] INT_VECTOR = 16'h0002
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] target,
  input  logic [DATA_W-1:0] pc_next,
  input  logic [3:0]        alu_flags,
  input  logic [3:0]        alu_flags_we,
  input  logic [DATA_W-1:0] pop_data,
  input  logic              pop_valid,
  input  logic              int_req,
  output logic [3:0]        ccr,
  output logic              jump_taken,
  output logic [DATA_W-1:0] jump_addr,
  output logic              push_req,
  output logic [DATA_W-1:0] push_data,
  output logic              pop_req,
  output logic              stall,
  output logic              int_ack
);

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_ccr, w_ccr_nxt;
  logic [3:0]        r_shadow, w_shadow_nxt;
  logic              r_in_isr, w_in_isr_nxt;
  logic              r_jump_taken, w_jump_taken_nxt;
  logic [DATA_W-1:0] r_jump_addr, w_jump_addr_nxt;
  logic              r_push_req, w_push_req_nxt;
  logic [DATA_W-1:0] r_push_data, w_push_data_nxt;
  logic              r_pop_req, w_pop_req_nxt;
  logic              r_int_ack, w_int_ack_nxt;

  logic [3:0]        w_eff;
  logic              w_taken;
  logic [3:0]        w_clr_mask;

  assign w_eff = merge_flags(r_ccr, alu_flags, alu_flags_we);

  branch_cond_eval u_cond (
    .i_op       (op),
    .i_eff      (w_eff),
    .o_taken    (w_taken),
    .o_clr_mask (w_clr_mask)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ccr        <= 4'b0000;
      r_shadow     <= 4'b0000;
      r_in_isr     <= 1'b0;
      r_jump_taken <= 1'b0;
      r_jump_addr  <= '0;
      r_push_req   <= 1'b0;
      r_push_data  <= '0;
      r_pop_req    <= 1'b0;
      r_int_ack    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ccr        <= w_ccr_nxt;
      r_shadow     <= w_shadow_nxt;
      r_in_isr     <= w_in_isr_nxt;
      r_jump_taken <= w_jump_taken_nxt;
      r_jump_addr  <= w_jump_addr_nxt;
      r_push_req   <= w_push_req_nxt;
      r_push_data  <= w_push_data_nxt;
      r_pop_req    <= w_pop_req_nxt;
      r_int_ack    <= w_int_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ccr_nxt        = w_eff;
    w_shadow_nxt     = r_shadow;
    w_in_isr_nxt     = r_in_isr;
    w_jump_taken_nxt = 1'b0;
    w_jump_addr_nxt  = r_jump_addr;
    w_push_req_nxt   = 1'b0;
    w_push_data_nxt  = r_push_data;
    w_pop_req_nxt    = 1'b0;
    w_int_ack_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (op_valid) begin
          case (op)
            OP_SETC: w_ccr_nxt[FLAG_C] = 1'b1;
            OP_CLRC: w_ccr_nxt[FLAG_C] = 1'b0;
            OP_JZ, OP_JN, OP_JC, OP_JMP: begin
              if (w_taken) begin
                w_jump_taken_nxt = 1'b1;
                w_jump_addr_nxt  = target;
                w_ccr_nxt        = w_eff & ~w_clr_mask;
              end
            end
            OP_CALL: begin
              w_push_req_nxt   = 1'b1;
              w_push_data_nxt  = pc_next;
              w_jump_taken_nxt = 1'b1;
              w_jump_addr_nxt  = target;
            end
            OP_RET: begin
              w_pop_req_nxt = 1'b1;
              w_state_nxt   = ST_RET_WAIT;
            end
            OP_RETI: begin
              w_pop_req_nxt = 1'b1;
              w_state_nxt   = ST_RETI_WAIT;
            end
            default: ;
          endcase
        end else if (int_req && !r_in_isr) begin
          // Interrupt entry: save flags, push return address, vector to the ISR.
          w_int_ack_nxt    = 1'b1;
          w_shadow_nxt     = w_eff;
          w_in_isr_nxt     = 1'b1;
          w_push_req_nxt   = 1'b1;
          w_push_data_nxt  = pc_next;
          w_jump_taken_nxt = 1'b1;
          w_jump_addr_nxt  = INT_VECTOR;
        end
      end
      ST_RET_WAIT: begin
        if (pop_valid) begin
          w_jump_taken_nxt = 1'b1;
          w_jump_addr_nxt  = pop_data;
          w_state_nxt      = ST_IDLE;
        end
      end
      ST_RETI_WAIT: begin
        if (pop_valid) begin
          w_jump_taken_nxt = 1'b1;
          w_jump_addr_nxt  = pop_data;
          w_ccr_nxt        = r_shadow;
          w_in_isr_nxt     = 1'b0;
          w_state_nxt      = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign ccr        = r_ccr;
  assign jump_taken = r_jump_taken;
  assign jump_addr  = r_jump_addr;
  assign push_req   = r_push_req;
  assign push_data  = r_push_data;
  assign pop_req    = r_pop_req;
  assign int_ack    = r_int_ack;
  assign stall      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_branch_flag_unit.sv
// Scoreboard bench for branch_flag_unit: a behavioural model with a stack queue predicts
// flags and output events; a monitor compares them after each clock edge.
module tb_branch_flag_unit;
  import branch_flag_unit_pkg::*;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          op_valid;
  logic [4:0]    op;
  logic [DW-1:0] target, pc_next, pop_data;
  logic [3:0]    alu_flags, alu_flags_we;
  logic          pop_valid, int_req;
  logic [3:0]    ccr;
  logic          jump_taken, push_req, pop_req, stall, int_ack;
  logic [DW-1:0] jump_addr, push_data;

  always #5 clk = ~clk;

  branch_flag_unit #(.DATA_W(DW), .INT_VECTOR(16'h0002)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .target(target),
    .pc_next(pc_next), .alu_flags(alu_flags), .alu_flags_we(alu_flags_we),
    .pop_data(pop_data), .pop_valid(pop_valid), .int_req(int_req), .ccr(ccr),
    .jump_taken(jump_taken), .jump_addr(jump_addr), .push_req(push_req),
    .push_data(push_data), .pop_req(pop_req), .stall(stall), .int_ack(int_ack)
  );

  typedef struct {
    bit            jt;
    logic [DW-1:0] ja;
    bit            pr;
    logic [DW-1:0] pd;
    bit            po;
    bit            ack;
  } ev_t;

  ev_t           evq[$];
  logic [DW-1:0] stack_q[$];
  logic [3:0]    m_ccr, m_shadow, exp_ccr;
  bit            m_in_isr, m_busy, m_reti, exp_stall;
  int            m_wait, m_delay, pop_delay, noise_pct;
  int            total, bad;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [3:0] model_merge(input logic [3:0] cur, input logic [3:0] f,
                                             input logic [3:0] we);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = we[b] ? f[b] : cur[b];
    return r;
  endfunction

  task automatic model_reset();
    m_ccr = 4'b0; m_shadow = 4'b0; m_in_isr = 0; m_busy = 0; m_reti = 0;
    m_wait = 0; m_delay = 0;
    evq.delete(); stack_q.delete();
    exp_ccr = 4'b0; exp_stall = 0;
  endtask

  // Drives one cycle of inputs and advances the reference model to the next edge.
  task automatic drive(input bit opv, input logic [4:0] o, input logic [DW-1:0] tgt,
                       input logic [DW-1:0] pcn, input logic [3:0] af, input logic [3:0] awe,
                       input bit irq);
    ev_t e;
    logic [3:0] eff;
    bit pv, has;
    logic [DW-1:0] pdv;
    int bi;
    pv = 0; has = 0;
    pdv = DW'($urandom);
    if (m_busy) begin
      pv = (m_wait == m_delay);
      m_wait++;
      if (pv && stack_q.size() > 0) pdv = stack_q.pop_back();
    end else begin
      pv = ($urandom_range(0, 99) < noise_pct);
    end
    op_valid = opv; op = o; target = tgt; pc_next = pcn;
    alu_flags = af; alu_flags_we = awe; int_req = irq;
    pop_valid = pv; pop_data = pdv;

    e.jt = 0; e.ja = '0; e.pr = 0; e.pd = '0; e.po = 0; e.ack = 0;
    eff = model_merge(m_ccr, af, awe);
    m_ccr = eff;
    if (m_busy) begin
      if (pv) begin
        e.jt = 1; e.ja = pdv; has = 1; m_busy = 0;
        if (m_reti) begin m_ccr = m_shadow; m_in_isr = 0; end
      end
    end else if (opv) begin
      case (o)
        OP_SETC: m_ccr[FLAG_C] = 1'b1;
        OP_CLRC: m_ccr[FLAG_C] = 1'b0;
        OP_JZ, OP_JN, OP_JC: begin
          bi = (o == OP_JZ) ? FLAG_Z : (o == OP_JN) ? FLAG_N : FLAG_C;
          if (eff[bi]) begin e.jt = 1; e.ja = tgt; has = 1; m_ccr[bi] = 1'b0; end
        end
        OP_JMP: begin e.jt = 1; e.ja = tgt; has = 1; end
        OP_CALL: begin
          e.jt = 1; e.ja = tgt; e.pr = 1; e.pd = pcn; has = 1;
          stack_q.push_back(pcn);
        end
        OP_RET, OP_RETI: begin
          e.po = 1; has = 1; m_busy = 1; m_reti = (o == OP_RETI); m_wait = 0;
          m_delay = (pop_delay >= 0) ? pop_delay : $urandom_range(0, 3);
        end
        default: ;
      endcase
    end else if (irq && !m_in_isr) begin
      e.ack = 1; e.jt = 1; e.ja = 16'h0002; e.pr = 1; e.pd = pcn; has = 1;
      m_shadow = eff; m_in_isr = 1;
      stack_q.push_back(pcn);
    end
    if (has) evq.push_back(e);
    exp_ccr = m_ccr;
    exp_stall = m_busy;
  endtask

  task automatic cyc(input bit opv, input logic [4:0] o, input logic [DW-1:0] tgt,
                     input logic [DW-1:0] pcn, input logic [3:0] af, input logic [3:0] awe,
                     input bit irq);
    @(negedge clk);
    drive(opv, o, tgt, pcn, af, awe, irq);
  endtask

  task automatic idle(input bit irq);
    cyc(0, 5'd0, 16'h0, 16'h0, 4'h0, 4'h0, irq);
  endtask

  // Monitor: flags and stall every cycle, events whenever the DUT presents one.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk);
      #1;
      check("ccr", 32'(ccr), 32'(exp_ccr));
      check("stall", 32'(stall), 32'(exp_stall));
      if (jump_taken || push_req || pop_req || int_ack) begin
        if (evq.size() == 0) begin
          check("unexpected_event", {28'b0, jump_taken, push_req, pop_req, int_ack}, 32'h0);
        end else begin
          e = evq.pop_front();
          check("event_kind", {28'b0, jump_taken, push_req, pop_req, int_ack},
                {28'b0, e.jt, e.pr, e.po, e.ack});
          if (e.jt) check("jump_addr", 32'(jump_addr), 32'(e.ja));
          if (e.pr) check("push_data", 32'(push_data), 32'(e.pd));
        end
      end else if (evq.size() > 0) begin
        e = evq.pop_front();
        check("missing_event", 32'h0, {28'b0, e.jt, e.pr, e.po, e.ack});
      end
    end
  end

  initial begin
    logic [4:0] codes[10];
    logic [4:0] oc;
    total = 0; bad = 0; pop_delay = -1; noise_pct = 0;
    codes = '{OP_SETC, OP_CLRC, OP_JZ, OP_JN, OP_JC, OP_JMP, OP_CALL, OP_RET, OP_RETI, 5'd0};
    reset = 1'b1;
    op_valid = 0; op = 0; target = 0; pc_next = 0; alu_flags = 0; alu_flags_we = 0;
    pop_data = 0; pop_valid = 0; int_req = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_jump_addr", 32'(jump_addr), 32'h0);
    check("reset_push_data", 32'(push_data), 32'h0);
    reset = 1'b0;
    drive(0, 5'd0, 16'h0, 16'h0, 4'h0, 4'h0, 0);

    // Forwarded Z flag taken by JZ, then cleared
    cyc(1, OP_JZ, 16'h0040, 16'h0005, 4'b0010, 4'b0010, 0);
    @(posedge clk); #2;
    check("fwd_jz_addr", 32'(jump_addr), 32'h0040);
    check("fwd_jz_ccr", 32'(ccr), 32'h0);
    // Not-taken JN, taken JC
    cyc(1, OP_SETC, 16'h0, 16'h0, 4'h0, 4'h0, 0);
    cyc(1, OP_JN, 16'h0077, 16'h0, 4'h0, 4'h0, 0);
    cyc(1, OP_JC, 16'h0100, 16'h0, 4'h0, 4'h0, 0);
    @(posedge clk); #2;
    check("jc_addr", 32'(jump_addr), 32'h0100);
    // CALL then RET with a three-cycle stall
    cyc(1, OP_CALL, 16'h0200, 16'h0011, 4'h0, 4'h0, 0);
    pop_delay = 2;
    cyc(1, OP_RET, 16'h0, 16'h0, 4'h0, 4'h0, 0);
    repeat (4) idle(0);
    // Interrupt entry, SETC in ISR, ignored second request, RETI restore
    cyc(0, 5'd0, 16'h0, 16'h0, 4'b1010, 4'b1111, 0);
    cyc(0, 5'd0, 16'h0, 16'h0033, 4'h0, 4'h0, 1);
    cyc(1, OP_SETC, 16'h0, 16'h0, 4'h0, 4'h0, 0);
    idle(1);
    pop_delay = 0;
    cyc(1, OP_RETI, 16'h0, 16'h0, 4'h0, 4'h0, 0);
    idle(0);
    @(posedge clk); #2;
    check("reti_ccr", 32'(ccr), 32'hA);
    check("reti_addr", 32'(jump_addr), 32'h0033);
    // Pending op wins over the interrupt, which lands on the next idle cycle
    cyc(1, OP_JMP, 16'h0055, 16'h0044, 4'h0, 4'h0, 1);
    idle(1);
    idle(0);
    // Reset while waiting on a pop abandons it
    cyc(0, 5'd0, 16'h0, 16'h0, 4'b0110, 4'b1111, 0);
    pop_delay = 10;
    cyc(1, OP_RET, 16'h0, 16'h0, 4'h0, 4'h0, 0);
    idle(0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_mid_ccr", 32'(ccr), 32'h0);
    check("rst_mid_stall", 32'(stall), 32'h0);
    check("rst_mid_strobes", {28'b0, jump_taken, push_req, pop_req, int_ack}, 32'h0);
    check("rst_mid_addr", 32'(jump_addr), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    noise_pct = 100;
    drive(0, 5'd0, 16'h0, 16'h0, 4'h0, 4'h0, 0);
    repeat (4) idle(0);

    // Randomized traffic
    pop_delay = -1;
    noise_pct = 10;
    for (int i = 0; i < 3000; i++) begin
      oc = codes[$urandom_range(0, 9)];
      if (oc == 5'd0) oc = 5'($urandom);
      cyc(bit'($urandom_range(0, 1)), oc, 16'($urandom), 16'($urandom),
          4'($urandom), 4'($urandom), ($urandom_range(0, 4) == 0));
    end
    repeat (6) idle(0);
    @(posedge clk); #2;
    check("queue_drained", 32'(evq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_flag_unit.md
Name: branch_flag_unit

Overview:
- Consumes the 4-bit condition flags from the ALU and owns the architectural condition-code register (CCR).
- Resolves the control-flow opcodes (JZ, JN, JC, JMP, CALL, RET, RETI) that the ALU passes through as no-ops, and drives jump redirects to the fetch stage.
- Sequences stack push/pop requests for CALL, RET, interrupt entry and RETI.
- Shadows the CCR across one interrupt level.

Parameters:
- DATA_W, 16, address/data width.
- INT_VECTOR, 16'h0002, ISR entry address driven on interrupt entry.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  op/target/pc_next are valid this cycle.
- op  in  5  control code: 1 SETC, 2 CLRC, 20 JZ, 21 JN, 22 JC, 23 JMP, 24 CALL, 25 RET, 26 RETI; other codes ignored.
- target  in  DATA_W  jump/call destination (register value).
- pc_next  in  DATA_W  address of the following instruction.
- alu_flags  in  4  ALU flag results; bit 0 carry, 1 zero, 2 negative, 3 overflow.
- alu_flags_we  in  4  per-bit write enable for alu_flags.
- pop_data  in  DATA_W  word returned by the stack.
- pop_valid  in  1  pop_data valid.
- int_req  in  1  level interrupt request.
- ccr  out  4  architectural flags.
- jump_taken  out  1  one-cycle redirect pulse.
- jump_addr  out  DATA_W  redirect address, valid with jump_taken.
- push_req  out  1  one-cycle stack push strobe.
- push_data  out  DATA_W  word to push.
- pop_req  out  1  one-cycle stack pop strobe.
- stall  out  1  high whenever state != IDLE; upstream holds op_valid/op.
- int_ack  out  1  one-cycle pulse on interrupt acceptance.

Behaviour:
- Reset (async, immediate): all outputs are 0 (ccr, jump_taken, jump_addr, push_req, push_data, pop_req, stall, int_ack); shadow_ccr = 0, in_isr = 0, state = IDLE.
- Flag merge, every cycle: eff = (ccr & ~alu_flags_we) | (alu_flags & alu_flags_we).
  - Decisions in that cycle use eff, so ALU forwarding is same-cycle.
  - The next ccr = eff plus any modification below.
  - The ALU write is applied first; an instruction modification then overrides it on the bit it touches.
- IDLE, op accepted when op_valid = 1. All outputs below are registered and appear on the next cycle.
  - SETC: ccr[0] = 1.
  - CLRC: ccr[0] = 0.
  - JZ / JN / JC: taken iff eff[1] / eff[2] / eff[0] is 1.
    - Taken: jump_taken = 1, jump_addr = target, and the tested bit is cleared in ccr.
    - Not taken: no output, ccr = eff.
  - JMP: always taken, flags untouched.
  - CALL: push_req = 1, push_data = pc_next, jump to target (both in the same cycle), then go to IDLE.
  - RET: pop_req = 1, go to RET_WAIT.
  - RETI: pop_req = 1, go to RETI_WAIT.
- Interrupt entry (IDLE only):
  - Condition: int_req = 1, op_valid = 0, in_isr = 0.
  - Action: int_ack = 1, shadow_ccr = eff, in_isr = 1, push_req = 1 with push_data = pc_next, jump_taken = 1 with jump_addr = INT_VECTOR.
  - Pending ops take priority over int_req.
  - int_req is ignored while in_isr = 1 (no nesting).
- RET_WAIT: hold stall = 1 until pop_valid.
  - On pop_valid: jump_taken = 1, jump_addr = pop_data, go to IDLE.
- RETI_WAIT: same as RET_WAIT, and additionally on pop_valid: ccr = shadow_ccr, in_isr = 0.
  - alu_flags_we is ignored in this cycle; the restore wins.
- stall is combinational from state and low in IDLE; op_valid is not consumed while stall = 1.
- Latency: single-cycle ops take 1 cycle to take effect. RET/RETI take 1 cycle plus the pop_valid wait (minimum 2).
- A reset during RET_WAIT or RETI_WAIT abandons the pop; no jump is issued.
- Unknown op codes are ignored: no outputs, ccr = eff.

Decomposition:
- Shared package holds:
  - opcode constants (SETC = 1, CLRC = 2, JZ = 20 … RETI = 26, kept identical to the ALU control encoding);
  - flag bit-index constants (FLAG_C = 0, FLAG_Z = 1, FLAG_N = 2, FLAG_V = 3);
  - the state enum (IDLE, RET_WAIT, RETI_WAIT).
- One natural sub-module: branch_cond_eval, combinational. It takes op and eff and returns taken plus the clear mask.

Test Plan:
- Reset mid-op: assert reset while in RET_WAIT -> all outputs 0 immediately, ccr = 0, no jump after release.
- Forwarding and clear: ccr = 4'b0000, alu_flags = 4'b0010 with we = 4'b0010 together with JZ, target = 16'h0040 -> next cycle jump_taken = 1, jump_addr = 16'h0040, ccr = 4'b0000.
- Jump not taken: ccr = 4'b0001, JN -> jump_taken = 0, ccr stays 4'b0001. Then JC, target = 16'h0100 -> jump_taken = 1, jump_addr = 16'h0100, ccr = 4'b0000.
- CALL then RET: CALL target = 16'h0200, pc_next = 16'h0011 -> push_req = 1, push_data = 16'h0011, jump_addr = 16'h0200. Then RET with pop_valid 3 cycles after pop_req, pop_data = 16'h0011 -> stall high for exactly 3 cycles, then jump_addr = 16'h0011.
- Interrupt save/restore: ccr = 4'b1010, int_req = 1, pc_next = 16'h0033 -> int_ack = 1, push_data = 16'h0033, jump_addr = 16'h0002. Inside the ISR, SETC gives ccr = 4'b1011 and a second int_req is ignored. RETI with pop_data = 16'h0033 -> ccr = 4'b1010, jump_addr = 16'h0033.
- Priority: op_valid = 1 with JMP and int_req = 1 in the same cycle -> JMP taken, int_ack = 0. The interrupt is accepted on the next idle cycle with op_valid = 0.
